// File: rtl/sipo_reg.sv
// -----------------------------------------------------------------------------
// sipo_reg -- serial-in parallel-out receiver
//
// Receiving end of the PISO shift-register link. One serial bit is taken on
// every clock with shift_en high; every WIDTH bits form a word that is
// presented on data_out under a valid/ack handshake. A word that completes
// while the previous one is still unconsumed is dropped and flagged by the
// sticky overrun output.
//
// Parameters:
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: first received bit lands in data_out[WIDTH-1]
//              0: first received bit lands in data_out[0]
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   shift_en    data_in carries a valid serial bit this cycle
//   data_in     serial bit
//   frame_clr   synchronous realign: drop the partial word, clear overrun
//   data_ack    consumer accepts the word on data_out
//   data_out    last completed word
//   data_valid  data_out holds an unconsumed word
//   overrun     sticky flag: a completed word was dropped
//   bit_cnt     bits received in the current partial word
// -----------------------------------------------------------------------------
module sipo_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     data_in,
  input  logic                     frame_clr,
  input  logic                     data_ack,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_shifted;
  logic             w_last;

  // Next shift-register value including the bit presented this cycle; on the
  // completion edge this is the finished word.
  always_comb begin
    w_shifted = r_sr;
    if (MSB_FIRST) begin
      w_shifted = {r_sr[WIDTH-2:0], data_in};
    end else begin
      w_shifted = {data_in, r_sr[WIDTH-1:1]};
    end
  end

  assign w_last = (r_bit_cnt == LAST_BIT);

  // Shift register, bit counter and handshake/overrun state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr         <= '0;
      r_bit_cnt    <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (frame_clr) begin
      // Realign wins over shifting; the output handshake keeps running.
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_overrun <= 1'b0;
      if (data_ack) begin
        r_data_valid <= 1'b0;
      end else begin
        r_data_valid <= r_data_valid;
      end
    end else if (shift_en) begin
      r_sr <= w_shifted;
      if (w_last) begin
        r_bit_cnt <= '0;
        // An ack on the completion edge frees the slot for the new word.
        if (!r_data_valid || data_ack) begin
          r_data_out   <= w_shifted;
          r_data_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        if (data_ack) begin
          r_data_valid <= 1'b0;
        end else begin
          r_data_valid <= r_data_valid;
        end
      end
    end else begin
      if (data_ack) begin
        r_data_valid <= 1'b0;
      end else begin
        r_data_valid <= r_data_valid;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign overrun    = r_overrun;
  assign bit_cnt    = r_bit_cnt;

endmodule

// File: doc/sipo_reg.md
Name: sipo_reg

Overview:
- Serial-in parallel-out receiver; the receiving end of the team's PISO shift-register link.
- Shifts in one bit per enabled clock and assembles WIDTH-bit words.
- Presents each completed word on a parallel output under a valid/ack handshake.
- Flags overrun when a new word completes before the previous word is consumed.

Parameters:
- WIDTH, 8, bits per word (>= 2).
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- shift_en  input  1  data_in is a valid serial bit this cycle.
- data_in  input  1  serial bit.
- frame_clr  input  1  synchronous realign: discard the partial word.
- data_ack  input  1  consumer accepts the word currently on data_out.
- data_out  output  WIDTH  last completed word.
- data_valid  output  1  data_out holds an unconsumed word.
- overrun  output  1  sticky: a completed word was dropped.
- bit_cnt  output  $clog2(WIDTH)  bits received in the current partial word.

Behaviour:
- Reset (rst=0, asynchronous): shift register, bit_cnt, data_out, data_valid and overrun all go to 0. Release is synchronous to the next clk edge. Reset mid-word discards the partial word.
- Shift, MSB_FIRST=1: sr <= {sr[WIDTH-2:0], data_in}.
- Shift, MSB_FIRST=0: sr <= {data_in, sr[WIDTH-1:1]}.
- shift_en=1 and bit_cnt < WIDTH-1: shift, then bit_cnt += 1.
- shift_en=1 and bit_cnt == WIDTH-1 (completion edge): the word is the shifted value including the current bit, and bit_cnt wraps to 0. Then one of:
  - data_valid=0, or data_ack=1 this cycle: data_out <= word, data_valid <= 1.
  - data_valid=1 and data_ack=0: word is dropped, data_out unchanged, overrun <= 1, data_valid stays 1.
- Latency: data_out/data_valid update on the same edge that samples the last bit, so they are visible one cycle after the last bit is presented.
- data_ack=1 with data_valid=1 and no completion: data_valid <= 0, data_out held.
- data_ack while data_valid=0: ignored.
- shift_en=0: no shift, bit_cnt held.
- frame_clr=1 (priority over shift_en):
  - shift register <= 0, bit_cnt <= 0, overrun <= 0.
  - data_out/data_valid are unaffected; a data_ack in the same cycle is still honoured.
  - The bit presented that cycle is discarded.
- bit_cnt wraps WIDTH-1 -> 0 only on completion; it never reaches WIDTH.
- Back-to-back words with shift_en held high are supported with no gap cycle.

Test Plan:
- Reset, release rst, shift_en=1 for 8 cycles with bits 0,0,0,0,1,1,1,1 (MSB_FIRST=1) -> data_out=8'h0F and data_valid=1 one cycle after the 8th bit. bit_cnt steps 0..7 then returns to 0.
- After 8'h0F, pulse data_ack, then shift in eight 1s then eight 0s with ack after each word -> data_out 8'hFF then 8'h00. data_valid deasserts the cycle after each ack. overrun stays 0.
- Complete 8'hA5, no ack, shift in 8'h3C -> data_out stays 8'hA5, data_valid=1, overrun=1. frame_clr then clears overrun; data_valid stays 1.
- With 8'hA5 pending, assert data_ack on the completion edge of 8'h3C -> data_out=8'h3C, data_valid stays 1, overrun=0.
- Shift 3 bits, assert frame_clr -> bit_cnt=0. A following 8'hC3 is received correctly.
- Shift 5 bits, assert rst=0 asynchronously between edges -> all outputs 0 immediately. After release, 8'h81 is received correctly.
- MSB_FIRST=0: bits 1,0,0,0,0,0,0,0 -> data_out=8'h01.
